// File: rtl/msrv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_pkg
// Description : Shared msrv32 core constants and the PC type.
// Revision    : 1.0 - initial release
// ============================================================================
package msrv32_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] BOOT_ADDRESS = 32'h0000_0000;

  typedef logic [XLEN-1:0] pc_t;

endpackage : msrv32_pkg
`default_nettype wire

// File: rtl/msrv32_reg_block_if.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_reg_block_if
// Description : Next-PC / current-PC bundle between the PC mux and PC register.
// Revision    : 1.0 - initial release
// ============================================================================
interface msrv32_reg_block_if;
  import msrv32_pkg::*;

  pc_t pc_mux;
  pc_t pc;

  // The PC mux side drives the next PC and observes the current PC.
  modport master (output pc_mux, input pc);
  modport slave  (input pc_mux, output pc);

endinterface : msrv32_reg_block_if
`default_nettype wire

// File: rtl/msrv32_reg_block.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_reg_block
// Description : PC register (pipeline stage 1); loads next PC every cycle,
//               synchronous reset loads BOOT_ADDRESS.
// Revision    : 1.0 - initial release
// ============================================================================
module msrv32_reg_block
  import msrv32_pkg::*;
#(
  parameter int unsigned     XLEN         = msrv32_pkg::XLEN,
  parameter logic [XLEN-1:0] BOOT_ADDRESS = msrv32_pkg::BOOT_ADDRESS
) (
  input  wire logic [XLEN-1:0] pc_mux_in,
  input  wire logic            clk_in,
  input  wire logic            rst_in,
  output logic      [XLEN-1:0] pc_out
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  always_comb begin
    pc_d = pc_mux_in;
    if (rst_in) begin
      pc_d = BOOT_ADDRESS;
    end
  end

  always_ff @(posedge clk_in) begin
    pc_q <= pc_d;
  end

  assign pc_out = pc_q;

`ifndef SYNTHESIS
  logic seen_rst_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      seen_rst_q <= 1'b1;
    end
  end

  a_rst_known : assert property (@(posedge clk_in) !$isunknown(rst_in))
    else $error("rst_in is X/Z");

  a_mux_known : assert property (@(posedge clk_in) !rst_in |-> !$isunknown(pc_mux_in))
    else $warning("pc_mux_in is X outside reset");

  a_boot_after_rst : assert property (@(posedge clk_in) $past(rst_in) |-> pc_out == BOOT_ADDRESS)
    else $error("pc_out not BOOT_ADDRESS after reset edge");

  // Before the first reset the previous-cycle input may have no history.
  a_follow_mux : assert property (@(posedge clk_in)
                                  ($past(seen_rst_q) && !$past(rst_in)) |-> pc_out == $past(pc_mux_in))
    else $error("pc_out does not match previous pc_mux_in");
`endif

endmodule : msrv32_reg_block
`default_nettype wire

// File: tb/tb_msrv32_reg_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_msrv32_reg_block
// Description : Scoreboard bench for the PC register with randomized stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msrv32_reg_block;
  import msrv32_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   stim_done;

  pc_t  exp_q[$];
  string name_q[$];

  msrv32_reg_block_if bus ();

  msrv32_reg_block #(
    .XLEN         (32),
    .BOOT_ADDRESS (32'h0000_0000)
  ) dut (
    .pc_mux_in (bus.pc_mux),
    .clk_in    (clk),
    .rst_in    (rst),
    .pc_out    (bus.pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus on the falling edge and record what the
  // register must show after the next rising edge.
  task automatic drive(input bit r, input pc_t v, input string nm);
    @(negedge clk);
    rst        = r;
    bus.pc_mux = v;
    exp_q.push_back(r ? pc_t'(32'h0000_0000) : v);
    name_q.push_back(nm);
  endtask

  // Monitor: after every rising edge, pop and compare if something is due.
  initial begin
    pc_t   e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (bus.pc !== e) begin
          errors++;
          $display("FAIL %s: pc_out=%h expected=%h", n, bus.pc, e);
        end
      end
    end
  end

  initial begin
    pc_t v;
    int  wait_cycles;
    checks = 0;
    errors = 0;
    stim_done = 1'b0;
    rst = 1'b1;
    bus.pc_mux = '0;

    drive(1'b1, 32'h0000_0000, "reset");
    drive(1'b0, 32'h0000_0004, "release");
    drive(1'b0, 32'h0000_0008, "follow");

    drive(1'b1, 32'h0000_FFFF, "rst_priority");
    drive(1'b0, 32'h0000_FFFF, "rst_priority_release");

    for (int i = 0; i < 25; i++) begin
      v = pc_t'($urandom % 165430);
      drive(1'b0, v, "rand_stream");
    end

    drive(1'b0, 32'hFFFF_FFFF, "ext_ones");
    drive(1'b0, 32'h8000_0000, "ext_msb");
    drive(1'b0, 32'h0000_0001, "ext_one");
    drive(1'b0, 32'h0000_0000, "ext_zero");
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0000_FFFF, "hold_const");

    drive(1'b0, 32'h0001_2344, "pre_midrst");
    drive(1'b1, 32'h0000_1234, "midrst_1");
    drive(1'b1, 32'h0000_1234, "midrst_2");
    drive(1'b0, 32'h0000_1234, "midrst_release");

    for (int i = 0; i < 20; i++) begin
      v = pc_t'($urandom);
      drive(($urandom_range(0, 7) == 0), v, "rand_full");
    end
    stim_done = 1'b1;

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_msrv32_reg_block
`default_nettype wire
